mem_dumper: RTL and testbench

Synthesizable hex-dump engine that walks a memory region over the 8-bit single-port memory interface and streams an ASCII dump (address, grouped hex bytes, optional printable column) to a character sink under valid/ready handshake. It moves the row-dump behaviour of the outer-interpreter bench into hardware, so TIB/OBUF inspection runs on silicon or FPGA via a UART or an OBUF writer. It is generalised in row width, grouping, address width and output mode, and adds a single-read row buffer, backpressure, abort and address wrap.

---
 rtl/dump_pkg.sv | 33 +++
 rtl/mem_dumper_if.sv | 30 +++
 rtl/dump_rowbuf.sv | 22 ++
 rtl/mem_dumper.sv | 200 ++++++++++++++++++++
 tb/tb_mem_dumper.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dump_pkg.sv
// Shared types and character helpers for the hex-dump engine.
// Imported by the dumper top and its row buffer.
package dump_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_NL,
        S_ADDR,
        S_COLON,
        S_SEP,
        S_FETCH,
        S_CAP,
        S_HI,
        S_LO,
        S_GAP,
        S_ASC,
        S_TAIL,
        S_DONE
    } state_t;

    localparam logic [7:0] NL    = 8'h0a;
    localparam logic [7:0] SPC   = 8'h20;
    localparam logic [7:0] COLON = 8'h3a;

    function automatic logic [7:0] hex_digit(input logic [3:0] d);
        return (d < 4'd10) ? (8'h30 + {4'h0, d}) : (8'h57 + {4'h0, d});
    endfunction

    function automatic logic printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7e);
    endfunction

endpackage

// File: rtl/mem_dumper_if.sv
// Memory read port and character stream of the hex-dump engine.
// master = dumper side, slave = memory / character sink side.
interface mem_dumper_if #(
    parameter int ASZ = 17
);
    logic [ASZ-1:0] mem_addr_o;
    logic           mem_rd_o;
    logic [7:0]     mem_data_i;
    logic [7:0]     char_o;
    logic           char_valid_o;
    logic           char_ready_i;

    modport master (
        output mem_addr_o,
        output mem_rd_o,
        input  mem_data_i,
        output char_o,
        output char_valid_o,
        input  char_ready_i
    );

    modport slave (
        input  mem_addr_o,
        input  mem_rd_o,
        output mem_data_i,
        input  char_o,
        input  char_valid_o,
        output char_ready_i
    );
endinterface

// File: rtl/dump_rowbuf.sv
// One-row byte store: written once per byte at capture, read
// asynchronously for both the hex digits and the ASCII column.
module dump_rowbuf #(
    parameter int ROW = 16,
    parameter int IW  = $clog2(ROW)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [IW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [IW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);
    logic [7:0] r_mem [ROW];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mem_dumper.sv
// Hex-dump engine: walks an aligned memory region row by row and
// streams address, grouped hex bytes and an optional ASCII column.
module mem_dumper
    import dump_pkg::*;
#(
    parameter int         ASZ = 17,
    parameter int         ROW = 16,
    parameter int         GRP = 4,
    parameter logic [7:0] DOT = 8'h2e
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start_i,
    input  logic [ASZ-1:0] addr_i,
    input  logic [ASZ-1:0] len_i,
    input  logic           ascii_i,
    input  logic           abort_i,
    output logic           busy_o,
    output logic           done_o,
    mem_dumper_if.master   bus
);
    localparam int AHEX = (ASZ + 3) / 4;
    localparam int IW   = $clog2(ROW);
    localparam int DW   = (AHEX > 1) ? $clog2(AHEX) : 1;

    state_t r_state;
    state_t w_state_nxt;

    logic [ASZ-1:0]    r_row_addr;
    logic [ASZ:0]      r_rows;
    logic [IW-1:0]     r_idx;
    logic [DW-1:0]     r_dig;
    logic              r_gap;
    logic              r_ascii;

    logic              w_acc;
    logic              w_last_byte;
    logic              w_last_dig;
    logic              w_grp_end;
    logic              w_last_row;
    logic [ASZ:0]      w_span;
    logic [ASZ:0]      w_nrows;
    logic [AHEX*4-1:0] w_addr_pad;
    logic [3:0]        w_nib;
    logic [7:0]        w_rd_data;
    state_t            w_row_end;

    assign w_acc       = bus.char_valid_o & bus.char_ready_i;
    assign w_last_byte = (r_idx == IW'(ROW - 1));
    assign w_last_dig  = (r_dig == DW'(AHEX - 1));
    assign w_grp_end   = ((r_idx + 1'b1) & IW'(GRP - 1)) == '0;
    assign w_last_row  = (r_rows == (ASZ + 1)'(1));
    assign w_row_end   = w_last_row ? S_TAIL : S_NL;

    // Row count covers the bytes before addr_i inside the first row.
    assign w_span  = {1'b0, addr_i & ASZ'(ROW - 1)} + {1'b0, len_i};
    assign w_nrows = (w_span + (ASZ + 1)'(ROW - 1)) >> IW;

    assign w_addr_pad = (AHEX * 4)'(r_row_addr);
    assign w_nib = 4'(w_addr_pad >> (4 * (AHEX - 1 - int'(r_dig))));

    dump_rowbuf #(
        .ROW (ROW),
        .IW  (IW)
    ) u_rowbuf (
        .clk     (clk),
        .i_we    (r_state == S_CAP),
        .i_waddr (r_idx),
        .i_wdata (bus.mem_data_i),
        .i_raddr (r_idx),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (start_i) w_state_nxt = (len_i == '0) ? S_DONE : S_NL;
            S_NL:    if (w_acc) w_state_nxt = S_ADDR;
            S_ADDR:  if (w_acc && w_last_dig) w_state_nxt = S_COLON;
            S_COLON: if (w_acc) w_state_nxt = S_SEP;
            S_SEP:   if (w_acc) w_state_nxt = S_FETCH;
            S_FETCH: w_state_nxt = S_CAP;
            S_CAP:   w_state_nxt = S_HI;
            S_HI:    if (w_acc) w_state_nxt = S_LO;
            S_LO: begin
                if (w_acc) begin
                    if (!w_last_byte) w_state_nxt = w_grp_end ? S_SEP : S_FETCH;
                    else if (r_ascii) w_state_nxt = S_GAP;
                    else              w_state_nxt = w_row_end;
                end
            end
            S_GAP:   if (w_acc && r_gap) w_state_nxt = S_ASC;
            S_ASC:   if (w_acc && w_last_byte) w_state_nxt = w_row_end;
            S_TAIL:  if (w_acc) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (abort_i && r_state != S_IDLE) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_addr <= '0;
            r_rows     <= '0;
            r_idx      <= '0;
            r_dig      <= '0;
            r_gap      <= 1'b0;
            r_ascii    <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_idx <= '0;
                    r_dig <= '0;
                    if (start_i) begin
                        r_row_addr <= addr_i & ~ASZ'(ROW - 1);
                        r_rows     <= w_nrows;
                        r_ascii    <= ascii_i;
                    end
                end
                S_ADDR: if (w_acc) r_dig <= w_last_dig ? '0 : r_dig + 1'b1;
                S_LO: begin
                    if (w_acc) begin
                        r_idx <= r_idx + 1'b1;
                        r_gap <= 1'b0;
                        if (w_last_byte && !r_ascii) begin
                            r_row_addr <= r_row_addr + ASZ'(ROW);
                            r_rows     <= r_rows - 1'b1;
                        end
                    end
                end
                S_GAP: if (w_acc) r_gap <= 1'b1;
                S_ASC: begin
                    if (w_acc) begin
                        r_idx <= r_idx + 1'b1;
                        if (w_last_byte) begin
                            r_row_addr <= r_row_addr + ASZ'(ROW);
                            r_rows     <= r_rows - 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done_o = (r_state == S_DONE);

    always_comb begin
        bus.char_valid_o = 1'b0;
        bus.char_o       = '0;
        bus.mem_rd_o     = 1'b0;
        bus.mem_addr_o   = '0;
        unique case (r_state)
            S_NL: begin
                bus.char_valid_o = 1'b1;
                bus.char_o       = NL;
            end
            S_ADDR: begin
                bus.char_valid_o = 1'b1;
                bus.char_o       = hex_digit(w_nib);
            end
            S_COLON: begin
                bus.char_valid_o = 1'b1;
                bus.char_o       = COLON;
            end
            S_SEP, S_GAP: begin
                bus.char_valid_o = 1'b1;
                bus.char_o       = SPC;
            end
            S_FETCH: begin
                bus.mem_rd_o   = 1'b1;
                bus.mem_addr_o = {r_row_addr[ASZ-1:IW], r_idx};
            end
            S_HI: begin
                bus.char_valid_o = 1'b1;
                bus.char_o       = hex_digit(w_rd_data[7:4]);
            end
            S_LO: begin
                bus.char_valid_o = 1'b1;
                bus.char_o       = hex_digit(w_rd_data[3:0]);
            end
            S_ASC: begin
                bus.char_valid_o = 1'b1;
                bus.char_o       = printable(w_rd_data) ? w_rd_data : DOT;
            end
            S_TAIL: begin
                bus.char_valid_o = 1'b1;
                bus.char_o       = NL;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_dumper.sv
// Scoreboard bench for mem_dumper: expected characters and read
// addresses are queued at stimulus time and popped by a monitor.
module tb_mem_dumper;
    localparam int ASZ = 17;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic           start_i;
    logic [ASZ-1:0] addr_i;
    logic [ASZ-1:0] len_i;
    logic           ascii_i;
    logic           abort_i;
    logic           busy_o;
    logic           done_o;

    mem_dumper_if #(.ASZ(ASZ)) bus ();

    mem_dumper #(
        .ASZ (ASZ),
        .ROW (16),
        .GRP (4),
        .DOT (8'h2e)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start_i),
        .addr_i  (addr_i),
        .len_i   (len_i),
        .ascii_i (ascii_i),
        .abort_i (abort_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .bus     (bus)
    );

    logic [7:0]     mem [0:(1<<ASZ)-1];
    logic [7:0]     exp_q [$];
    logic [ASZ-1:0] addr_q [$];

    int total = 0;
    int bad   = 0;
    int n_acc = 0;
    int n_done = 0;
    int rmode = 0;
    int acc_lim = 0;
    logic       held_v = 1'b0;
    logic [7:0] held_c = 8'h00;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    task automatic push_addrs(input logic [ASZ-1:0] base, input int n);
        for (int i = 0; i < n; i++) addr_q.push_back(ASZ'(32'(base) + i));
    endtask

    task automatic mon();
        logic [7:0]     e;
        logic [ASZ-1:0] ea;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (held_v && bus.char_valid_o)
                    chk("char_hold", bus.char_o, held_c);
                held_v = bus.char_valid_o && !bus.char_ready_i;
                held_c = bus.char_o;
                if (bus.char_valid_o && bus.char_ready_i) begin
                    n_acc++;
                    if (exp_q.size() == 0) begin
                        chk("extra_char", bus.char_o, 32'hffff_ffff);
                    end else begin
                        e = exp_q.pop_front();
                        chk("char", bus.char_o, e);
                    end
                end
                if (bus.mem_rd_o) begin
                    if (addr_q.size() == 0) begin
                        chk("extra_read", bus.mem_addr_o, 32'hffff_ffff);
                    end else begin
                        ea = addr_q.pop_front();
                        chk("rd_addr", bus.mem_addr_o, ea);
                    end
                    bus.mem_data_i = mem[bus.mem_addr_o];
                end
                if (done_o) n_done++;
            end
        end
    endtask

    task automatic sink();
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                1:       bus.char_ready_i = ~bus.char_ready_i;
                2:       bus.char_ready_i = (n_acc < acc_lim);
                default: bus.char_ready_i = 1'b1;
            endcase
        end
    endtask

    task automatic kick(input logic [ASZ-1:0] a, input logic [ASZ-1:0] l,
                        input logic asc);
        @(negedge clk);
        addr_i  = a;
        len_i   = l;
        ascii_i = asc;
        start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
    endtask

    task automatic run(input string nm, input logic [ASZ-1:0] a,
                       input logic [ASZ-1:0] l, input logic asc);
        int d0;
        d0 = n_done;
        kick(a, l, asc);
        @(negedge clk);
        if (l != '0) chk({nm, "/busy"}, busy_o, 1);
        for (int c = 0; c < 4000 && n_done == d0; c++) @(negedge clk);
        chk({nm, "/done"}, n_done - d0, 1);
        chk({nm, "/busy_low"}, busy_o, 0);
        @(negedge clk);
        chk({nm, "/done_width"}, done_o, 0);
        chk({nm, "/chars_left"}, exp_q.size(), 0);
        chk({nm, "/reads_left"}, addr_q.size(), 0);
    endtask

    task automatic check_idle_outputs(input string nm);
        chk({nm, "/busy"}, busy_o, 0);
        chk({nm, "/done"}, done_o, 0);
        chk({nm, "/valid"}, bus.char_valid_o, 0);
        chk({nm, "/rd"}, bus.mem_rd_o, 0);
        chk({nm, "/char"}, bus.char_o, 0);
        chk({nm, "/maddr"}, bus.mem_addr_o, 0);
    endtask

    localparam string ROW1A =
        "\n01000: 00010203 04050607 08090a0b 0c0d0e0f  ................\n";

    initial begin
        int d0;
        rst_n   = 1'b0;
        start_i = 1'b0;
        abort_i = 1'b0;
        ascii_i = 1'b0;
        addr_i  = '0;
        len_i   = '0;
        bus.char_ready_i = 1'b1;
        bus.mem_data_i   = 8'h00;
        for (int i = 0; i < (1 << ASZ); i++) mem[i] = 8'(i);
        fork
            mon();
            sink();
        join_none

        #12;
        check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        push_str(ROW1A);
        push_addrs(17'h1000, 16);
        run("ascii_row", 17'h1003, 17'd5, 1'b1);

        push_str({"\n01000: 00010203 04050607 08090a0b 0c0d0e0f",
                  "\n01010: 10111213 14151617 18191a1b 1c1d1e1f\n"});
        push_addrs(17'h1000, 32);
        run("hex_2rows", 17'h1000, 17'h11, 1'b0);

        rmode = 1;
        push_str(ROW1A);
        push_addrs(17'h1000, 16);
        run("backpressure", 17'h1003, 17'd5, 1'b1);
        rmode = 0;

        mem[17'h1000] = 8'h41;
        mem[17'h1001] = 8'h7f;
        mem[17'h1002] = 8'h1f;
        mem[17'h1003] = 8'h20;
        push_str("\n01000: 417f1f20 04050607 08090a0b 0c0d0e0f  A.. ............\n");
        push_addrs(17'h1000, 16);
        run("printable", 17'h1000, 17'd4, 1'b1);
        for (int i = 0; i < 4; i++) mem[17'h1000 + i] = 8'(i);

        push_str({"\n1fff0: f0f1f2f3 f4f5f6f7 f8f9fafb fcfdfeff",
                  "\n00000: 00010203 04050607 08090a0b 0c0d0e0f\n"});
        push_addrs(17'h1fff0, 32);
        run("wrap", 17'h1fff8, 17'h10, 1'b0);

        run("zero_len", 17'h1234, 17'h0, 1'b1);

        push_str("\n01000: 00010203 ");
        push_addrs(17'h1000, 5);
        acc_lim = n_acc + 17;
        rmode = 2;
        d0 = n_done;
        kick(17'h1000, 17'h20, 1'b1);
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (n_acc == acc_lim && bus.char_valid_o && !bus.char_ready_i)
                break;
        end
        chk("abort/stalled_hi", bus.char_o, "0");
        abort_i = 1'b1;
        @(posedge clk);
        #1 abort_i = 1'b0;
        @(negedge clk);
        chk("abort/valid", bus.char_valid_o, 0);
        chk("abort/busy", busy_o, 0);
        repeat (3) @(negedge clk);
        chk("abort/no_done", n_done - d0, 0);
        chk("abort/chars_left", exp_q.size(), 0);
        chk("abort/reads_left", addr_q.size(), 0);
        rmode = 0;

        push_str(ROW1A);
        push_addrs(17'h1000, 16);
        run("after_abort", 17'h1003, 17'd5, 1'b1);

        push_str(ROW1A);
        push_addrs(17'h1000, 16);
        kick(17'h1003, 17'd5, 1'b1);
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("async_rst");
        exp_q.delete();
        addr_q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        push_str(ROW1A);
        push_addrs(17'h1000, 16);
        run("after_rst", 17'h1003, 17'd5, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
